// File: rtl/led_fader.sv
// Soft-fade PWM stage: each LED channel ramps an 8-bit brightness toward its
// on/off target and is driven by comparing that level with a free-running PWM counter.
module led_fader #(
  parameter logic [31:0] STEP_DIV = 32'd46875,
  parameter int          N_LED    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_LED-1:0] led_in,
  input  logic             enable,
  output logic [N_LED-1:0] led_out,
  output logic             busy
);

  logic [N_LED-1:0]      ledIn_q;
  logic [7:0]            pwmCnt_q, pwmCnt_d;
  logic [31:0]           stepCnt_q, stepCnt_d;
  logic [N_LED-1:0][7:0] level_q, level_d;
  logic [N_LED-1:0]      ledOut_q, ledOut_d;
  logic                  busy_q, busy_d;
  logic                  stepTick;

  assign stepTick = (stepCnt_q == STEP_DIV - 32'd1);

  // Bypass mode snaps every level to its target so re-enabling fades is glitch-free.
  always_comb begin
    pwmCnt_d  = pwmCnt_q + 8'd1;
    stepCnt_d = (!enable || stepTick) ? 32'd0 : stepCnt_q + 32'd1;
    level_d   = level_q;
    ledOut_d  = '0;
    busy_d    = 1'b0;
    for (int i = 0; i < N_LED; i++) begin
      if (!enable) begin
        level_d[i]  = ledIn_q[i] ? 8'hFF : 8'h00;
        ledOut_d[i] = ledIn_q[i];
      end else begin
        if (stepTick) begin
          if (ledIn_q[i] && (level_q[i] != 8'hFF)) begin
            level_d[i] = level_q[i] + 8'd1;
          end else if (!ledIn_q[i] && (level_q[i] != 8'h00)) begin
            level_d[i] = level_q[i] - 8'd1;
          end
        end
        ledOut_d[i] = (level_q[i] == 8'hFF) || (level_q[i] > pwmCnt_q);
      end
      if (level_q[i] != (ledIn_q[i] ? 8'hFF : 8'h00)) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ledIn_q   <= '0;
      pwmCnt_q  <= 8'd0;
      stepCnt_q <= 32'd0;
      level_q   <= '0;
      ledOut_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      ledIn_q   <= led_in;
      pwmCnt_q  <= pwmCnt_d;
      stepCnt_q <= stepCnt_d;
      level_q   <= level_d;
      ledOut_q  <= ledOut_d;
      busy_q    <= busy_d;
    end
  end

  assign led_out = ledOut_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader: a STEP_DIV=4 instance for ramp/bypass/reset
// scenarios and a STEP_DIV=1024 instance for the PWM duty measurement.
module tb_led_fader;

  logic       clk;
  logic       rstNA, enableA, rstNB, enableB;
  logic [7:0] ledInA, ledOutA, ledInB, ledOutB;
  logic       busyA, busyB;
  int         checkCount;
  int         errorCount;

  led_fader #(.STEP_DIV(32'd4), .N_LED(8)) dutA (
    .clk(clk), .rst_n(rstNA), .led_in(ledInA), .enable(enableA),
    .led_out(ledOutA), .busy(busyA)
  );

  led_fader #(.STEP_DIV(32'd1024), .N_LED(8)) dutB (
    .clk(clk), .rst_n(rstNB), .led_in(ledInB), .enable(enableB),
    .led_out(ledOutB), .busy(busyB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic [7:0] ledIn, input logic en);
    rstNA   = rstN;
    ledInA  = ledIn;
    enableA = en;
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic flagA, flagB;
    int   highCount;
    checkCount = 0;
    errorCount = 0;
    rstNB   = 1'b0;
    ledInB  = 8'h01;
    enableB = 1'b1;

    $display("[TB] reset behaviour");
    applyStimulus(1'b0, 8'hFF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      waitCycles(1);
      checkOutput("t1 rstLedOut", ledOutA, 32'h00);
      checkOutput("t1 rstBusy", busyA, 32'h0);
    end
    applyStimulus(1'b1, 8'hFF, 1'b1);
    waitCycles(1);
    checkOutput("t1 relLedOut", ledOutA, 32'h00);
    checkOutput("t1 relBusy", busyA, 32'h0);
    waitCycles(1);
    checkOutput("t1 busyRise", busyA, 32'h1);

    $display("[TB] full ramp of channel 0");
    applyStimulus(1'b0, 8'h01, 1'b1);
    waitCycles(1);
    applyStimulus(1'b1, 8'h01, 1'b1);
    waitCycles(1);
    checkOutput("t2 busyE1", busyA, 32'h0);
    flagA = (ledOutA[7:1] == 7'd0);
    flagB = 1'b1;
    for (int e = 2; e <= 1020; e++) begin
      waitCycles(1);
      if (busyA !== 1'b1) flagB = 1'b0;
      if (ledOutA[7:1] !== 7'd0) flagA = 1'b0;
    end
    checkOutput("t2 busyHeld", flagB, 32'h1);
    waitCycles(1);
    checkOutput("t2 busyFall", busyA, 32'h0);
    checkOutput("t2 fullOn", ledOutA[0], 32'h1);
    for (int k = 0; k < 300; k++) begin
      waitCycles(1);
      if (ledOutA[7:1] !== 7'd0) flagA = 1'b0;
      if ((ledOutA[0] !== 1'b1) || (busyA !== 1'b0)) flagB = 1'b0;
    end
    checkOutput("t2 upperOff", flagA, 32'h1);
    checkOutput("t2 steadyOn", flagB, 32'h1);

    $display("[TB] ramp up to 100 then down");
    applyStimulus(1'b0, 8'h01, 1'b1);
    waitCycles(1);
    applyStimulus(1'b1, 8'h01, 1'b1);
    waitCycles(400);
    checkOutput("t4 busyAt100", busyA, 32'h1);
    applyStimulus(1'b1, 8'h00, 1'b1);
    waitCycles(400);
    checkOutput("t4 busyLast", busyA, 32'h1);
    waitCycles(1);
    checkOutput("t4 busyFall", busyA, 32'h0);
    flagA = 1'b1;
    for (int k = 0; k < 256; k++) begin
      waitCycles(1);
      if ((ledOutA !== 8'h00) || (busyA !== 1'b0)) flagA = 1'b0;
    end
    checkOutput("t4 steadyOff", flagA, 32'h1);

    $display("[TB] bypass and re-enable");
    applyStimulus(1'b1, 8'hAA, 1'b0);
    waitCycles(1);
    checkOutput("t5 latency1", ledOutA, 32'h00);
    waitCycles(1);
    checkOutput("t5 latency2", ledOutA, 32'hAA);
    waitCycles(1);
    checkOutput("t5 bypassBusy", busyA, 32'h0);
    checkOutput("t5 bypassOut", ledOutA, 32'hAA);
    waitCycles(3);
    applyStimulus(1'b1, 8'hAA, 1'b1);
    flagA = 1'b1;
    flagB = 1'b1;
    for (int k = 0; k < 300; k++) begin
      waitCycles(1);
      if (ledOutA[1] !== 1'b1) flagA = 1'b0;
      if ((ledOutA !== 8'hAA) || (busyA !== 1'b0)) flagB = 1'b0;
    end
    checkOutput("t5 bit1Steady", flagA, 32'h1);
    checkOutput("t5 noGlitch", flagB, 32'h1);

    $display("[TB] reset mid-ramp");
    applyStimulus(1'b0, 8'h01, 1'b1);
    waitCycles(1);
    applyStimulus(1'b1, 8'h01, 1'b1);
    waitCycles(512);
    checkOutput("t6 midBusy", busyA, 32'h1);
    applyStimulus(1'b0, 8'h01, 1'b1);
    waitCycles(1);
    checkOutput("t6 rstLedOut", ledOutA, 32'h00);
    checkOutput("t6 rstBusy", busyA, 32'h0);
    applyStimulus(1'b1, 8'h01, 1'b1);
    flagA = 1'b1;
    for (int k = 0; k < 8; k++) begin
      waitCycles(1);
      if (ledOutA !== 8'h00) flagA = 1'b0;
    end
    checkOutput("t6 levelCleared", flagA, 32'h1);
    waitCycles(1012);
    checkOutput("t6 restartBusy", busyA, 32'h1);
    waitCycles(1);
    checkOutput("t6 restartDone", busyA, 32'h0);

    $display("[TB] PWM duty at level 64");
    rstNB = 1'b1;
    waitCycles(65536);
    highCount = 0;
    flagA = 1'b1;
    for (int k = 0; k < 256; k++) begin
      waitCycles(1);
      if (ledOutB[0] === 1'b1) highCount++;
      if (ledOutB[7:1] !== 7'd0) flagA = 1'b0;
    end
    checkOutput("t3 dutyCount", highCount, 32'd64);
    checkOutput("t3 upperOff", flagA, 32'h1);
    checkOutput("t3 busy", busyB, 32'h1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
